bf16_iterative_divider: RTL and testbench

- Sequential bf16 divider, the inverse of the team's combinational bf16 multiplier.
- Computes quotient = a / b with the same field handling: 1 sign, 8 exponent, 7 mantissa bits, bias 127, truncation, flush-to-zero.
- Uses a restoring mantissa divider, one quotient bit per cycle, with valid/ready handshakes on both sides.
- Sits in the compute cluster beside the multiplier for normalisation/scale operations.

---
 rtl/bf16_pkg.sv | 27 ++
 rtl/bf16_iterative_divider_if.sv | 24 ++
 rtl/bf16_lzc.sv | 15 +
 rtl/bf16_iterative_divider.sv | 174 +++++++++++++++++
 tb/tb_bf16_iterative_divider.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/bf16_pkg.sv
// Shared bf16 field definitions, FSM state encoding and special-value constants
// for the bf16 arithmetic blocks.
package bf16_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 7;
    localparam int unsigned BIAS   = 127;
    localparam int unsigned SIG_W  = MANT_W + 1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } bf16_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NORM  = 3'd1,
        ST_DIV   = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [15:0]      BF16_QNAN    = 16'h7FC0;
    localparam logic [EXP_W-1:0] BF16_EXP_MAX = 8'hFF;

endpackage

// File: rtl/bf16_iterative_divider_if.sv
// Operand/result valid-ready bundle for the bf16 iterative divider.
interface bf16_iterative_divider_if;
    import bf16_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [$bits(bf16_t)-1:0] a;
    logic [$bits(bf16_t)-1:0] b;
    logic                     out_valid;
    logic                     out_ready;
    logic [$bits(bf16_t)-1:0] out;
    logic                     div_by_zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, div_by_zero
    );

endinterface

// File: rtl/bf16_lzc.sv
// 8-bit leading-zero counter; returns 8 for an all-zero input.
module bf16_lzc (
    input  logic [7:0] value,
    output logic [3:0] count
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        count = 4'd8;
        for (int i = 0; i < 8; i++) begin
            if (value[i]) count = 4'(7 - i);
        end
    end

endmodule

// File: rtl/bf16_iterative_divider.sv
// Sequential bf16 divider: restoring mantissa division, one quotient bit per cycle,
// truncation and flush-to-zero. Define BF16_DIV_SPECIALS_EN for NaN/inf handling.
module bf16_iterative_divider
    import bf16_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    bf16_iterative_divider_if.slave bus
);

    localparam int unsigned QBITS = MANT_W + 2;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned XW    = EXP_W + 2;

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_NORM  = ST_NORM;
    localparam logic [2:0] S_DIV   = ST_DIV;
    localparam logic [2:0] S_FINAL = ST_FINAL;
    localparam logic [2:0] S_DONE  = ST_DONE;

    logic [2:0]             state, state_nx;
    logic                   ready_r, valid_r, dbz_r;
    bf16_t                  out_r;
    bf16_t                  a_r, b_r;
    logic [SIG_W-1:0]       dvs;
    logic [QBITS-1:0]       rem, q;
    logic [CNT_W-1:0]       cnt;
    logic signed [XW-1:0]   exp_r;
    logic                   sign_r, zero_a_r, zero_b_r;

    logic [SIG_W-1:0]       sig_a, sig_b, sh_a, sh_b;
    logic [3:0]             lz_a, lz_b;
    logic                   zero_a, zero_b;
    logic signed [XW-1:0]   ea, eb;
    logic                   q_bit;
    logic [QBITS-1:0]       rem_sub;
    logic signed [XW-1:0]   exp_f;
    logic [MANT_W-1:0]      mant_f;
    bf16_t                  res;
    logic                   res_dbz;

    assign bus.in_ready    = ready_r;
    assign bus.out_valid   = valid_r;
    assign bus.out         = out_r;
    assign bus.div_by_zero = dbz_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state   <= state_nx;
            ready_r <= (state_nx == S_IDLE);
            valid_r <= (state_nx == S_DONE);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.in_valid) state_nx = S_NORM;
            S_NORM:  state_nx = S_DIV;
            S_DIV:   if (cnt == CNT_W'(QBITS - 1)) state_nx = S_FINAL;
            S_FINAL: state_nx = S_DONE;
            S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    bf16_lzc u_lzc_a (.value(sig_a), .count(lz_a));
    bf16_lzc u_lzc_b (.value(sig_b), .count(lz_b));

    // Operand normalisation: subnormals get exponent 1 and are shifted left.
    always_comb begin
        sig_a  = {|a_r.exp, a_r.mant};
        sig_b  = {|b_r.exp, b_r.mant};
        zero_a = (sig_a == '0);
        zero_b = (sig_b == '0);
        sh_a   = zero_a ? sig_a : SIG_W'(sig_a << lz_a);
        sh_b   = zero_b ? sig_b : SIG_W'(sig_b << lz_b);
        ea     = signed'(XW'((a_r.exp == '0) ? EXP_W'(1) : a_r.exp))
               - signed'(XW'(zero_a ? 4'd0 : lz_a));
        eb     = signed'(XW'((b_r.exp == '0) ? EXP_W'(1) : b_r.exp))
               - signed'(XW'(zero_b ? 4'd0 : lz_b));
    end

    always_comb begin
        q_bit   = (rem >= QBITS'(dvs));
        rem_sub = q_bit ? (rem - QBITS'(dvs)) : rem;
    end

    // Post-normalise the quotient, then apply the special-case overrides.
    always_comb begin
        exp_f    = q[QBITS-1] ? exp_r : (exp_r - signed'(XW'(1)));
        mant_f   = q[QBITS-1] ? q[QBITS-2:1] : q[QBITS-3:0];
        res.sign = sign_r;
        res.exp  = exp_f[EXP_W-1:0];
        res.mant = mant_f;
        res_dbz  = 1'b0;
`ifdef BF16_DIV_SPECIALS_EN
        if (((a_r.exp == BF16_EXP_MAX) && (a_r.mant != '0)) ||
            ((b_r.exp == BF16_EXP_MAX) && (b_r.mant != '0)) ||
            (zero_a_r && zero_b_r) ||
            ((a_r.exp == BF16_EXP_MAX) && (b_r.exp == BF16_EXP_MAX))) begin
            res = bf16_t'(BF16_QNAN);
        end else if (a_r.exp == BF16_EXP_MAX) begin
            res.exp  = BF16_EXP_MAX;
            res.mant = '0;
        end else if (b_r.exp == BF16_EXP_MAX) begin
            res.exp  = '0;
            res.mant = '0;
        end else
`endif
        if (zero_b_r) begin
            res.exp  = BF16_EXP_MAX;
            res.mant = '0;
            res_dbz  = 1'b1;
        end else if (zero_a_r || (exp_f <= signed'(XW'(0)))) begin
            res.exp  = '0;
            res.mant = '0;
        end else if (exp_f >= signed'(XW'(BF16_EXP_MAX))) begin
            res.exp  = BF16_EXP_MAX;
            res.mant = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            dvs      <= '0;
            rem      <= '0;
            q        <= '0;
            cnt      <= '0;
            exp_r    <= '0;
            sign_r   <= 1'b0;
            zero_a_r <= 1'b0;
            zero_b_r <= 1'b0;
            out_r    <= '0;
            dbz_r    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_r <= bus.a;
                        b_r <= bus.b;
                    end
                end
                S_NORM: begin
                    rem      <= QBITS'(sh_a);
                    dvs      <= sh_b;
                    q        <= '0;
                    cnt      <= '0;
                    exp_r    <= ea - eb + signed'(XW'(BIAS));
                    sign_r   <= a_r.sign ^ b_r.sign;
                    zero_a_r <= zero_a;
                    zero_b_r <= zero_b;
                end
                S_DIV: begin
                    rem <= QBITS'({rem_sub, 1'b0});
                    q   <= {q[QBITS-2:0], q_bit};
                    cnt <= cnt + CNT_W'(1);
                end
                S_FINAL: begin
                    out_r <= res;
                    dbz_r <= res_dbz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bf16_iterative_divider.sv
// Directed bench for bf16_iterative_divider: hand-computed quotients, latency,
// back-pressure and mid-operation reset.
module tb_bf16_iterative_divider;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    bf16_iterative_divider_if bus();

    bf16_iterative_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic start_op(input string tag, input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        check({tag, "_ready"}, 16'(bus.in_ready), 16'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = ~av;
        bus.b        = ~bv;
    endtask

    task automatic wait_result(input string tag, input logic [15:0] eo, input logic ed);
        int   edges = 0;
        logic ready_seen = 1'b0;
        while (bus.out_valid !== 1'b1 && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.in_ready !== 1'b0) ready_seen = 1'b1;
        end
        check({tag, "_latency"}, 16'(edges), 16'd11);
        check({tag, "_busy"}, 16'(ready_seen), 16'd0);
        check({tag, "_out"}, bus.out, eo);
        check({tag, "_dbz"}, 16'(bus.div_by_zero), 16'(ed));
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_drop"}, 16'(bus.out_valid), 16'd0);
        check({tag, "_idle"}, 16'(bus.in_ready), 16'd1);
    endtask

    task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] eo, input logic ed);
        start_op(tag, av, bv);
        wait_result(tag, eo, ed);
        release_out(tag);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        #12;
        check("rst_in_ready", 16'(bus.in_ready), 16'd1);
        check("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("rst_out", bus.out, 16'h0000);
        check("rst_dbz", 16'(bus.div_by_zero), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("two_by_one", 16'h4000, 16'h3F80, 16'h4000, 1'b0);
        do_op("one_third",  16'h3F80, 16'h4040, 16'h3EAA, 1'b0);
        do_op("subnormals", 16'h0040, 16'h0040, 16'h3F80, 1'b0);
        do_op("neg_by_zero", 16'hBF80, 16'h0000, 16'hFF80, 1'b1);
`ifdef BF16_DIV_SPECIALS_EN
        do_op("zero_zero",  16'h0000, 16'h0000, 16'h7FC0, 1'b0);
        do_op("nan_in",     16'h7FC1, 16'h3F80, 16'h7FC0, 1'b0);
        do_op("inf_fin",    16'hFF80, 16'h4000, 16'hFF80, 1'b0);
        do_op("fin_inf",    16'h3F80, 16'h7F80, 16'h0000, 1'b0);
        do_op("inf_inf",    16'h7F80, 16'h7F80, 16'h7FC0, 1'b0);
`else
        do_op("zero_zero",  16'h0000, 16'h0000, 16'h7F80, 1'b1);
        do_op("maxexp_fin", 16'h7F80, 16'h7F80, 16'h3F80, 1'b0);
`endif
        do_op("underflow",  16'h0080, 16'h4000, 16'h0000, 1'b0);
        do_op("overflow",   16'h7F00, 16'h3F00, 16'h7F80, 1'b0);

        // Back-pressure: result held while a competing request is presented.
        start_op("hold", 16'h3F80, 16'h4000);
        wait_result("hold", 16'h3F00, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 16'h4000;
        bus.b        = 16'h3F80;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_out", bus.out, 16'h3F00);
            check("hold_dbz", 16'(bus.div_by_zero), 16'd0);
            check("hold_valid", 16'(bus.out_valid), 16'd1);
            check("hold_ready", 16'(bus.in_ready), 16'd0);
        end
        release_out("hold");
        start_op("after_hold", 16'h4000, 16'h3F80);
        wait_result("after_hold", 16'h4000, 1'b0);
        release_out("after_hold");

        // Reset while the divide loop is at count 4.
        start_op("abort", 16'h4000, 16'h4000);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 16'(bus.in_ready), 16'd1);
        check("abort_out_valid", 16'(bus.out_valid), 16'd0);
        check("abort_out", bus.out, 16'h0000);
        check("abort_dbz", 16'(bus.div_by_zero), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_reset", 16'h4000, 16'h4000, 16'h3F80, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
